wam_mole: RTL and testbench

- Mole generator: the producer side of the hole/hit interface. Drives `holes` (which moles are up), which the hit qualifier consumes, and takes back its registered `hit` vector.
- A pseudo-random spawn timer raises moles for a level-dependent time. Each mole is retired on a hit. A mole that times out unhit raises a per-hole miss pulse.
- Runs on the slow game clock, alongside the tap and hit logic and ahead of the score counter.

---
 rtl/wam_pkg.sv | 27 ++
 rtl/wam_lfsr.sv | 25 ++
 rtl/wam_mole.sv | 170 +++++++++++++++++
 tb/tb_wam_mole.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wam_pkg.sv
// Shared types and constants for the mole generator: hole states, LFSR setup,
// counter width and the level-scaled time helper.
package wam_pkg;

    typedef enum logic [1:0] {
        HS_IDLE  = 2'd0,
        HS_UP    = 2'd1,
        HS_GRACE = 2'd2
    } hole_state_e;

    localparam int unsigned NHOLE_MAX = 8;
    localparam int unsigned LFSR_W    = 16;
    localparam int unsigned CNT_W     = 8;

    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR (bit 0 is tap 16)
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'h002D;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    // Level-scaled duration; a zero result would never expire, so it becomes 1
    function automatic logic [CNT_W-1:0] clamp_time(input int unsigned base,
                                                    input logic [1:0]  lvl);
        logic [CNT_W-1:0] t;
        t = CNT_W'(base >> lvl);
        return (t == '0) ? CNT_W'(1) : t;
    endfunction

endpackage

// File: rtl/wam_lfsr.sv
// Free-running 16-bit Fibonacci LFSR that picks spawn candidates; it ignores the
// game enable so the sequence keeps moving between rounds.
module wam_lfsr
    import wam_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk_19,
    input  logic              clr_n,
    output logic [LFSR_W-1:0] q
);

    logic fb;

    assign fb = ^(q & LFSR_TAPS);

    always_ff @(posedge clk_19 or negedge clr_n) begin
        if (!clr_n) begin
            q <= SEED;
        end else begin
            q <= {fb, q[LFSR_W-1:1]};
        end
    end

endmodule

// File: rtl/wam_mole.sv
// Mole generator: spawns moles into holes on a pseudo-random schedule, retires
// them on hits and flags a miss when a mole expires unhit.
module wam_mole
    import wam_pkg::*;
#(
    parameter int unsigned       NHOLE    = 8,
    parameter int unsigned       UP_BASE  = 96,
    parameter int unsigned       GAP_BASE = 64,
    parameter int unsigned       MAX_UP   = 3,
    parameter int unsigned       GRACE_T  = 2,
    parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED
) (
    input  logic             clk_19,
    input  logic             clr_n,
    input  logic             en,
    input  logic [1:0]       level,
    input  logic [NHOLE-1:0] hit,
    output logic [NHOLE-1:0] holes,
    output logic [NHOLE-1:0] miss,
    output logic             busy
);

    localparam int unsigned      IDX_W    = (NHOLE > 1) ? $clog2(NHOLE) : 1;
    localparam int unsigned      ACT_W    = $clog2(NHOLE_MAX + 1);
    localparam logic [CNT_W-1:0] GRACE_LD = CNT_W'(GRACE_T);
    localparam logic [CNT_W-1:0] GAP_RST  = clamp_time(GAP_BASE, 2'd0);

    logic [LFSR_W-1:0] lfsr_q;
    logic [IDX_W-1:0]  cand;
    logic [CNT_W-1:0]  up_time;
    logic [CNT_W-1:0]  gap;
    logic [CNT_W-1:0]  timer_q;
    logic [CNT_W-1:0]  timer_d;
    logic [ACT_W-1:0]  act_cnt;
    logic              spawn;
    logic [NHOLE-1:0]  spawn_vec;
    logic [NHOLE-1:0]  active_q;
    logic [NHOLE-1:0]  active_d;
    logic [NHOLE-1:0]  up_d;
    logic [NHOLE-1:0]  miss_d;
    logic              unused_lfsr;

    wam_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk_19 (clk_19),
        .clr_n  (clr_n),
        .q      (lfsr_q)
    );

    assign up_time     = clamp_time(UP_BASE, level);
    assign gap         = clamp_time(GAP_BASE, level);
    assign cand        = lfsr_q[IDX_W-1:0];
    assign unused_lfsr = ^lfsr_q[LFSR_W-1:IDX_W];

    // Moles in UP or GRACE both count against the concurrency limit
    always_comb begin
        act_cnt = '0;
        for (int i = 0; i < NHOLE; i++) begin
            act_cnt = act_cnt + ACT_W'(active_q[i]);
        end
    end

    assign spawn     = en && (timer_q == '0) && !active_q[cand] &&
                       (act_cnt < ACT_W'(MAX_UP));
    assign spawn_vec = spawn ? (NHOLE'(1) << cand) : '0;

    // Spawn timer parks at zero and retries every cycle until a spawn lands
    always_comb begin
        timer_d = timer_q;
        if (!en || spawn) begin
            timer_d = gap;
        end else if (timer_q != '0) begin
            timer_d = timer_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_19 or negedge clr_n) begin
        if (!clr_n) begin
            timer_q <= GAP_RST;
        end else begin
            timer_q <= timer_d;
        end
    end

    for (genvar gi = 0; gi < NHOLE; gi++) begin : g_hole
        hole_state_e      st_q;
        hole_state_e      st_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             up_c;
        logic             act_c;
        logic             miss_c;

        always_ff @(posedge clk_19 or negedge clr_n) begin
            if (!clr_n) begin
                st_q  <= HS_IDLE;
                cnt_q <= '0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
            end
        end

        // A hit always beats a timeout landing on the same cycle
        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            if (!en) begin
                st_d  = HS_IDLE;
                cnt_d = '0;
            end else begin
                unique case (st_q)
                    HS_IDLE: begin
                        if (spawn_vec[gi]) begin
                            st_d  = HS_UP;
                            cnt_d = up_time;
                        end
                    end
                    HS_UP: begin
                        if (hit[gi]) begin
                            st_d = HS_IDLE;
                        end else if (cnt_q == CNT_W'(1)) begin
                            st_d  = HS_GRACE;
                            cnt_d = GRACE_LD;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    HS_GRACE: begin
                        if (hit[gi] || (cnt_q == CNT_W'(1))) begin
                            st_d = HS_IDLE;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        st_d  = HS_IDLE;
                        cnt_d = '0;
                    end
                endcase
            end
        end

        always_comb begin
            up_c   = (st_d == HS_UP);
            act_c  = (st_d != HS_IDLE);
            miss_c = en && (st_q == HS_GRACE) && !hit[gi] && (cnt_q == CNT_W'(1));
        end

        assign up_d[gi]     = up_c;
        assign active_d[gi] = act_c;
        assign miss_d[gi]   = miss_c;
        assign active_q[gi] = (st_q != HS_IDLE);
    end

    // Outputs follow the state being entered, so holes aligns with UP exactly
    always_ff @(posedge clk_19 or negedge clr_n) begin
        if (!clr_n) begin
            holes <= '0;
            miss  <= '0;
            busy  <= 1'b0;
        end else begin
            holes <= up_d;
            miss  <= miss_d;
            busy  <= |active_d;
        end
    end

endmodule

// File: tb/tb_wam_mole.sv
// Directed bench for wam_mole: a cycle model fills a scoreboard of expected
// outputs, alongside hand-derived checks on timing, hits, limits and reset.
module tb_wam_mole;

    localparam int unsigned NH  = 8;
    localparam int unsigned UPB = 8;
    localparam int unsigned GPB = 4;
    localparam int unsigned MXU = 3;
    localparam int unsigned GRT = 2;
    localparam logic [15:0] SEED_V = 16'hACE1;

    typedef struct packed {
        logic [NH-1:0] holes;
        logic [NH-1:0] miss;
        logic          busy;
    } exp_t;

    logic          clk_19 = 1'b0;
    logic          clr_n  = 1'b1;
    logic          en     = 1'b0;
    logic [1:0]    level  = 2'd0;
    logic [NH-1:0] hit    = '0;
    logic [NH-1:0] holes;
    logic [NH-1:0] miss;
    logic          busy;

    int errs   = 0;
    int checks = 0;

    exp_t          exp_q[$];
    int            m_st[NH];
    int            m_left[NH];
    int            m_timer;
    logic [15:0]   m_lfsr;
    logic [NH-1:0] m_holes;

    wam_mole #(
        .NHOLE    (NH),
        .UP_BASE  (UPB),
        .GAP_BASE (GPB),
        .MAX_UP   (MXU),
        .GRACE_T  (GRT),
        .SEED     (SEED_V)
    ) dut (
        .clk_19 (clk_19),
        .clr_n  (clr_n),
        .en     (en),
        .level  (level),
        .hit    (hit),
        .holes  (holes),
        .miss   (miss),
        .busy   (busy)
    );

    always #5 clk_19 = ~clk_19;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NH; i++) begin
            m_st[i]   = 0;
            m_left[i] = 0;
        end
        m_timer = GPB;
        m_lfsr  = SEED_V;
        m_holes = '0;
        exp_q.delete();
    endtask

    // States: 0 idle, 1 up, 2 grace; m_left is the cycles still to spend there
    task automatic model_step();
        int            up_t;
        int            gp;
        int            act;
        int            cand;
        bit            spawn;
        exp_t          e;
        up_t = int'(UPB >> level);
        if (up_t == 0) up_t = 1;
        gp = int'(GPB >> level);
        if (gp == 0) gp = 1;
        act = 0;
        for (int i = 0; i < NH; i++) if (m_st[i] != 0) act++;
        cand  = int'(m_lfsr[2:0]);
        spawn = en && (m_timer == 0) && (m_st[cand] == 0) && (act < int'(MXU));
        e.miss = '0;
        for (int i = 0; i < NH; i++) begin
            if (!en) begin
                m_st[i] = 0;
            end else if (m_st[i] == 0) begin
                if (spawn && i == cand) begin
                    m_st[i]   = 1;
                    m_left[i] = up_t;
                end
            end else if (hit[i]) begin
                m_st[i] = 0;
            end else if (m_left[i] > 1) begin
                m_left[i]--;
            end else if (m_st[i] == 1) begin
                m_st[i]   = 2;
                m_left[i] = GRT;
            end else begin
                m_st[i]   = 0;
                e.miss[i] = 1'b1;
            end
        end
        if (!en || spawn) m_timer = gp;
        else if (m_timer > 0) m_timer--;
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        e.busy = 1'b0;
        for (int i = 0; i < NH; i++) begin
            e.holes[i] = (m_st[i] == 1);
            if (m_st[i] != 0) e.busy = 1'b1;
        end
        m_holes = e.holes;
        exp_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_step();
        @(posedge clk_19);
        #1;
        e = exp_q.pop_front();
        check("sb_holes", 32'(holes), 32'(e.holes));
        check("sb_miss",  32'(miss),  32'(e.miss));
        check("sb_busy",  32'(busy),  32'(e.busy));
    endtask

    // Async reset asserted between edges; outputs must clear without a clock
    task automatic do_reset();
        en  = 1'b0;
        hit = '0;
        level = 2'd0;
        #2 clr_n = 1'b0;
        #1;
        check("rst_holes", 32'(holes), 32'd0);
        check("rst_miss",  32'(miss),  32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_lfsr",  32'(dut.u_lfsr.q), 32'(SEED_V));
        model_reset();
        @(posedge clk_19);
        #1 clr_n = 1'b1;
    endtask

    task automatic wait_mole(output int k, output int n);
        n = 0;
        k = 0;
        while (m_holes == '0 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (m_holes == '0) begin
            errs++;
            $error("FAIL wait_mole: observed no mole after %0d cycles, expected one", n);
        end else begin
            for (int i = NH - 1; i >= 0; i--) if (m_holes[i]) k = i;
        end
    endtask

    initial begin
        int k;
        int n;
        int spawns;
        int misses;
        logic [NH-1:0] pending;
        logic [NH-1:0] prev;
        logic [NH-1:0] rise;

        // Unhit mole: latency, one-hot, up time, grace, single miss
        do_reset();
        en = 1'b1;
        wait_mole(k, n);
        check("spawn_latency", 32'(n), 32'd5);
        check("onehot", 32'($countones(holes)), 32'd1);
        for (int s = 2; s <= 8; s++) begin
            step();
            check("up_high", 32'(holes[k]), 32'd1);
        end
        for (int s = 0; s < 2; s++) begin
            step();
            check("grace_low", 32'(holes[k]), 32'd0);
            check("grace_nomiss", 32'(miss[k]), 32'd0);
        end
        step();
        check("miss_pulse", 32'(miss[k]), 32'd1);
        step();
        check("miss_single", 32'(miss[k]), 32'd0);

        // Hit during the third up cycle
        do_reset();
        en = 1'b1;
        wait_mole(k, n);
        step();
        step();
        hit[k] = 1'b1;
        step();
        hit = '0;
        check("hit_drop", 32'(holes[k]), 32'd0);
        for (int s = 0; s < 10; s++) begin
            step();
            check("hit_nomiss", 32'(miss[k]), 32'd0);
        end

        // Hit on the last up cycle, where the timeout would also fire
        do_reset();
        en = 1'b1;
        wait_mole(k, n);
        for (int s = 0; s < 7; s++) step();
        hit[k] = 1'b1;
        step();
        hit = '0;
        check("lastup_drop", 32'(holes[k]), 32'd0);
        for (int s = 0; s < 4; s++) begin
            step();
            check("lastup_nomiss", 32'(miss[k]), 32'd0);
        end

        // Hit on the second grace cycle, where the miss would otherwise fire
        do_reset();
        en = 1'b1;
        wait_mole(k, n);
        for (int s = 0; s < 8; s++) step();
        check("in_grace", 32'(holes[k]), 32'd0);
        step();
        hit[k] = 1'b1;
        step();
        hit = '0;
        check("grace_hit_nomiss", 32'(miss[k]), 32'd0);
        for (int s = 0; s < 3; s++) begin
            step();
            check("grace_hit_quiet", 32'(miss[k]), 32'd0);
        end

        // Long unhit run: concurrency limit and spawn/miss accounting
        do_reset();
        en = 1'b1;
        pending = '0;
        prev    = '0;
        spawns  = 0;
        misses  = 0;
        for (int s = 0; s < 200; s++) begin
            step();
            rise = holes & ~prev;
            check("respawn_in_grace", 32'(rise & pending), 32'd0);
            spawns += $countones(rise);
            pending |= rise;
            check("orphan_miss", 32'(miss & ~pending), 32'd0);
            misses += $countones(miss);
            pending &= ~miss;
            check("max_up", 32'($countones(holes) <= int'(MXU)), 32'd1);
            prev = holes;
        end
        check("spawn_miss_balance", 32'(misses + $countones(pending)), 32'(spawns));
        check("spawn_activity", 32'(spawns > 10), 32'd1);

        // Level 2: up time 2
        do_reset();
        level = 2'd2;
        en = 1'b1;
        wait_mole(k, n);
        step();
        check("lvl2_up2", 32'(holes[k]), 32'd1);
        step();
        check("lvl2_down", 32'(holes[k]), 32'd0);
        for (int s = 0; s < 12; s++) step();

        // Level 3: up time 1, gap clamped to 1
        do_reset();
        level = 2'd3;
        en = 1'b1;
        wait_mole(k, n);
        step();
        check("lvl3_up1", 32'(holes[k]), 32'd0);
        for (int s = 0; s < 12; s++) step();

        // Disable with two moles up, then resume with a fresh gap
        do_reset();
        en = 1'b1;
        n = 0;
        while ($countones(m_holes) < 2 && n < 60) begin
            step();
            n++;
        end
        checks++;
        if ($countones(m_holes) < 2) begin
            errs++;
            $error("FAIL two_up: observed %0d moles, expected 2", $countones(m_holes));
        end
        en = 1'b0;
        step();
        check("dis_holes", 32'(holes), 32'd0);
        check("dis_miss",  32'(miss),  32'd0);
        check("dis_busy",  32'(busy),  32'd0);
        for (int s = 0; s < 3; s++) begin
            step();
            check("dis_quiet", 32'(miss), 32'd0);
        end
        en = 1'b1;
        wait_mole(k, n);
        check("resume_gap", 32'(n), 32'd5);
        for (int s = 0; s < 3; s++) step();

        // Mid-game async reset
        do_reset();
        step();
        check("post_rst_idle", 32'(holes), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
